// File: rtl/neuron_input_loader_pkg.sv
// neuron_pkg: shared word/vector types and present-FSM states for the loader
package neuron_pkg;
    localparam int WIDTH    = 32;
    localparam int N_INPUTS = 32;
    localparam int IDX_W    = $clog2(N_INPUTS + 1);
    typedef logic [WIDTH-1:0] word_t;
    typedef word_t [N_INPUTS-1:0] vec_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, SHOW} state_t;
endpackage

// File: rtl/neuron_input_loader_if.sv
// neuron_input_loader_if: serial sample word stream (source drives, loader accepts)
interface neuron_input_loader_if;
    logic               s_valid;
    logic               s_ready;
    logic               s_last;
    neuron_pkg::word_t  s_data;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/neuron_input_loader_buffer.sv
// sample_buffer: one N_INPUTS+1 word bank, indexed write, parallel read of inputs and target
module sample_buffer
    import neuron_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  idx_t  widx,
    input  word_t wdata,
    output vec_t  vec,
    output word_t tgt
);
    word_t [N_INPUTS:0] mem;
    // store the accepted word at its frame position
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mem <= '0;
        else if (we) mem[widx] <= wdata;
    assign vec = mem[N_INPUTS-1:0];
    assign tgt = mem[N_INPUTS];
endmodule

// File: rtl/neuron_input_loader.sv
// neuron_input_loader: frames a serial word stream into ping-pong sample buffers and presents each sample for a settle window
module neuron_input_loader
    import neuron_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuron_input_loader_if.slave  s,
    input  logic                  hold,
    output vec_t                  in_vec,
    output word_t                 target,
    output logic                  sample_valid,
    output logic                  sample_done,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      sample_count
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    idx_t          widx;
    logic          fill_sel, fill_full, resync;
    state_t        state;
    logic [CW-1:0] cnt;
    vec_t          vec0, vec1;
    word_t         tgt0, tgt1;
    logic          acc, at_tgt, we, good_tgt, swap, full_nxt;
    assign acc         = s.s_valid && s.s_ready;
    assign at_tgt      = widx == idx_t'(N_INPUTS);
    assign we          = acc && !resync && (at_tgt ? s.s_last : !s.s_last);
    assign good_tgt    = we && at_tgt;
    assign sample_done = state == SHOW && cnt == '0 && !hold;
    assign swap        = fill_full && (state == IDLE || sample_done);
    assign full_nxt    = good_tgt || (fill_full && !swap);
    assign in_vec      = fill_sel ? vec0 : vec1;
    assign target      = fill_sel ? tgt0 : tgt1;
    sample_buffer u_buf0 (.clk(clk), .rst_n(rst_n), .we(we && !fill_sel), .widx(widx), .wdata(s.s_data), .vec(vec0), .tgt(tgt0));
    sample_buffer u_buf1 (.clk(clk), .rst_n(rst_n), .we(we && fill_sel), .widx(widx), .wdata(s.s_data), .vec(vec1), .tgt(tgt1));
    // fill side: word index, framing checks, resync drop mode and ready/full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx      <= '0;
            resync    <= 1'b0;
            frame_err <= 1'b0;
            fill_full <= 1'b0;
            fill_sel  <= 1'b0;
            s.s_ready <= 1'b0;
        end else begin
            fill_full <= full_nxt;
            s.s_ready <= !full_nxt;
            if (swap) fill_sel <= !fill_sel;
            if (acc) begin
                if (resync) begin
                    if (s.s_last) resync <= 1'b0;
                end else if (at_tgt) begin
                    widx <= '0;
                    if (!s.s_last) begin
                        frame_err <= 1'b1;
                        resync    <= 1'b1;
                    end
                end else if (s.s_last) begin
                    widx      <= '0;
                    frame_err <= 1'b1;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
        end
    end
    // present side: swap in full buffers and count down the settle window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
        end else begin
            if (swap) begin
                state        <= SHOW;
                cnt          <= CNT_LOAD;
                sample_valid <= 1'b1;
            end else if (sample_done) begin
                state        <= IDLE;
                sample_valid <= 1'b0;
            end else if (state == SHOW && !hold) begin
                cnt <= cnt - 1'b1;
            end
            if (sample_done) sample_count <= sample_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_neuron_input_loader.sv
// tb_neuron_input_loader: randomized and directed stream stimulus checked against a queue-based sample model
module tb_neuron_input_loader;
    import neuron_pkg::*;
    localparam int S = 4;
    logic        clk = 0, rst_n = 0, hold_d = 0, rnd_en = 0, rh = 0;
    logic        hold;
    vec_t        in_vec;
    word_t       target;
    logic        sample_valid, sample_done, frame_err;
    logic [15:0] sample_count;
    int          tests = 0, fails = 0, n_done = 0;
    neuron_input_loader_if bus();
    assign hold = hold_d | (rnd_en & rh);
    neuron_input_loader #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus), .hold(hold), .in_vec(in_vec), .target(target),
        .sample_valid(sample_valid), .sample_done(sample_done), .frame_err(frame_err), .sample_count(sample_count)
    );
    always #5 clk = ~clk;
    always @(negedge clk) rh = ($urandom_range(0, 3) == 0);

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t g, input word_t gt, input vec_t e, input word_t et);
        int bad = -1;
        tests++;
        for (int i = N_INPUTS - 1; i >= 0; i--) if (g[i] !== e[i]) bad = i;
        if (bad >= 0 || gt !== et) begin
            fails++;
            if (bad >= 0) $display("FAIL %s: word %0d got %h expected %h", nm, bad, g[bad], e[bad]);
            else $display("FAIL %s: target got %h expected %h", nm, gt, et);
        end
    endtask

    // behavioural model: frames assemble in a queue, presentation tracked as remaining settle cycles
    word_t       cur[$];
    vec_t        m_fv = '0, m_pv = '0;
    word_t       m_ft = '0, m_pt = '0;
    bit          m_full, m_valid, m_ready, m_err, m_resync, acc_m, done_m;
    int          m_left;
    logic [15:0] m_count = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.delete();
            m_full = 0; m_valid = 0; m_ready = 0; m_err = 0; m_resync = 0; m_left = 0; m_count = '0;
            m_pv = '0; m_pt = '0;
        end else begin
            done_m = m_valid && m_left == 1 && !hold;
            acc_m  = bus.s_valid && m_ready;
            if (m_full && (!m_valid || done_m)) begin
                m_pv = m_fv; m_pt = m_ft; m_full = 0; m_valid = 1; m_left = S;
            end else if (done_m) m_valid = 0;
            else if (m_valid && !hold) m_left--;
            if (done_m) m_count++;
            if (acc_m) begin
                if (m_resync) begin
                    if (bus.s_last) m_resync = 0;
                end else if (cur.size() == N_INPUTS) begin
                    if (bus.s_last) begin
                        foreach (cur[i]) m_fv[i] = cur[i];
                        m_ft = bus.s_data; m_full = 1;
                    end else begin
                        m_err = 1; m_resync = 1;
                    end
                    cur.delete();
                end else if (bus.s_last) begin
                    m_err = 1; cur.delete();
                end else cur.push_back(bus.s_data);
            end
            m_ready = !m_full;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("s_ready", bus.s_ready, m_ready);
        chk("sample_valid", sample_valid, m_valid);
        chk("sample_done", sample_done, m_valid && m_left == 1 && !hold);
        chk("frame_err", frame_err, m_err);
        chk("sample_count", sample_count, m_count);
        chk_vec("in_vec", in_vec, target, m_pv, m_pt);
        if (sample_done) n_done++;
    end

    task automatic send(input word_t w, input bit l);
        int t = 0;
        bus.s_valid = 1; bus.s_data = w; bus.s_last = l;
        while (!bus.s_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin tests++; fails++; $display("FAIL send timeout: s_ready stuck 0"); end
        @(negedge clk);
        bus.s_valid = 0; bus.s_last = 0;
    endtask

    task automatic send_frame(input vec_t v, input word_t t);
        for (int i = 0; i < N_INPUTS; i++) send(v[i], 0);
        send(t, 1);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!sample_valid && t < 200) begin @(negedge clk); t++; end
        chk("wait sample_valid", sample_valid, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sample_valid && t < 200) begin @(negedge clk); t++; end
        chk("wait idle", sample_valid, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst sample_valid", sample_valid, 0);
        chk("rst s_ready", bus.s_ready, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst sample_count", sample_count, 0);
        chk("rst target", target, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    vec_t  ev;
    int    len, done_at, nd0;
    logic [15:0] c0;
    initial begin
        bus.s_valid = 0; bus.s_last = 0; bus.s_data = '0;
        repeat (2) @(negedge clk);
        chk("reset s_ready", bus.s_ready, 0);
        chk("reset sample_count", sample_count, 0);
        chk("reset in_vec0", in_vec[0], 0);
        rst_n = 1;
        @(negedge clk);
        chk("s_ready after release", bus.s_ready, 1);
        // single frame
        foreach (ev[i]) ev[i] = word_t'(i + 1);
        nd0 = n_done;
        send_frame(ev, 32'hFFF);
        chk("t1 valid before swap", sample_valid, 0);
        @(negedge clk);
        chk("t1 valid after swap", sample_valid, 1);
        chk_vec("t1 in_vec", in_vec, target, ev, 32'hFFF);
        len = 0;
        while (sample_valid && len < 100) begin len++; @(negedge clk); end
        chk("t1 valid length", len, 4);
        chk("t1 done pulses", n_done - nd0, 1);
        chk("t1 sample_count", sample_count, 1);
        // three frames back to back
        nd0 = n_done; c0 = sample_count;
        for (int f = 0; f < 3; f++) begin
            foreach (ev[i]) ev[i] = $urandom;
            send_frame(ev, $urandom);
        end
        repeat (10) @(negedge clk);
        chk("t2 done pulses", n_done - nd0, 3);
        chk("t2 sample_count", sample_count, c0 + 3);
        // early s_last on word 10
        pulse_reset();
        for (int i = 0; i < 9; i++) send(word_t'(i), 0);
        send(32'h9, 1);
        repeat (3) @(negedge clk);
        chk("t3 frame_err", frame_err, 1);
        chk("t3 no sample", sample_valid, 0);
        foreach (ev[i]) ev[i] = 32'hA5;
        send_frame(ev, 32'hA5);
        @(negedge clk);
        chk("t3 good valid", sample_valid, 1);
        chk_vec("t3 in_vec", in_vec, target, ev, 32'hA5);
        wait_idle();
        chk("t3 sample_count", sample_count, 1);
        // missing s_last then resync
        pulse_reset();
        for (int i = 0; i < 33; i++) send(word_t'(100 + i), 0);
        for (int i = 0; i < 5; i++) send(word_t'(200 + i), i == 4);
        repeat (3) @(negedge clk);
        chk("t4 frame_err", frame_err, 1);
        chk("t4 no sample", sample_valid, 0);
        foreach (ev[i]) ev[i] = word_t'(3 * i);
        send_frame(ev, 32'h77);
        @(negedge clk);
        chk_vec("t4 in_vec", in_vec, target, ev, 32'h77);
        wait_idle();
        chk("t4 sample_count", sample_count, 1);
        // hold for three cycles mid-SHOW
        foreach (ev[i]) ev[i] = $urandom;
        send_frame(ev, 32'h5);
        wait_valid();
        len = 0; done_at = 0;
        while (sample_valid && len < 100) begin
            len++;
            if (len == 2) hold_d = 1;
            if (len == 5) hold_d = 0;
            if (sample_done) done_at = len;
            @(negedge clk);
        end
        chk("t5 held valid length", len, 7);
        chk("t5 done cycle", done_at, 7);
        // reset mid-fill, then mid-SHOW
        for (int i = 0; i < 20; i++) send(word_t'(i), 0);
        pulse_reset();
        foreach (ev[i]) ev[i] = word_t'(i ^ 32'h3C);
        send_frame(ev, 32'h1234);
        wait_valid();
        chk_vec("t6 in_vec", in_vec, target, ev, 32'h1234);
        wait_idle();
        chk("t6 sample_count", sample_count, 1);
        send_frame(ev, 32'h4321);
        wait_valid();
        pulse_reset();
        chk("t6 after show reset", sample_valid, 0);
        // randomized frames with framing errors, gaps and hold jitter
        rnd_en = 1;
        for (int f = 0; f < 25; f++) begin
            int kind = $urandom_range(0, 5);
            if (kind == 0) begin
                int k = $urandom_range(0, N_INPUTS - 1);
                for (int i = 0; i < k; i++) send($urandom, 0);
                send($urandom, 1);
            end else if (kind == 1) begin
                int j = $urandom_range(0, 3);
                for (int i = 0; i < N_INPUTS + 1 + j; i++) send($urandom, 0);
                send($urandom, 1);
            end else begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    send($urandom, 0);
                    if ($urandom_range(0, 7) == 0) @(negedge clk);
                end
                send($urandom, 1);
            end
        end
        rnd_en = 0;
        repeat (40) @(negedge clk);
        chk("final idle", sample_valid, 0);
        chk("final count", sample_count, m_count);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
